out_pcm_encoder: RTL and testbench

- Output PCM stage of the multi-channel ADPCM (G.726-style) decoder.
- Converts the 16-bit two's-complement reconstructed linear sample SR into an 8-bit G.711 PCM code SP, either µ-law or A-law, selected per sample.
- One registered pipeline stage; carries scan ports for DFT chain stitching.

---
 rtl/out_pcm_encoder.sv | 87 ++++++++
 tb/tb_out_pcm_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/out_pcm_encoder.sv
// Output PCM stage: converts a 16-bit two's-complement linear sample into an
// 8-bit G.711 code (mu-law or A-law chosen per sample), one registered stage.
// Scan ports are placeholders for DFT stitching; functionally inert here.
module out_pcm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sr,
    input  logic        law,
    input  logic        in_valid,
    output logic [7:0]  sp,
    output logic        out_valid,
    input  logic        scan_en,
    input  logic        scan_in0,
    output logic        scan_out0
);

    logic        is_neg;
    logic [14:0] im;

    // mu-law path
    logic [12:0] mu_b;
    logic [2:0]  mu_seg;
    logic [3:0]  mu_q;
    logic [7:0]  mu_code;

    // A-law path
    logic [15:0] a_sum;
    logic [14:0] a_imag;
    logic [11:0] a_m;
    logic [2:0]  a_seg;
    logic [3:0]  a_q;
    logic [7:0]  a_code;

    logic        unused_scan;

    // Sign/magnitude split; the 15-bit negate makes 16'h8000 fold to zero magnitude.
    assign is_neg = sr[15];
    assign im     = is_neg ? (~sr[14:0] + 15'd1) : sr[14:0];

    // mu-law: clip, bias by 33, segment from the leading one at or above bit 5.
    always_comb begin
        mu_b   = (im > 15'd8158) ? 13'd8191 : (im[12:0] + 13'd33);
        mu_seg = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mu_b[i + 5]) begin
                mu_seg = 3'(i);
            end
        end
        mu_q    = 4'(mu_b >> ({1'b0, mu_seg} + 4'd1));
        mu_code = ~{is_neg, mu_seg, mu_q};
    end

    // A-law: halve magnitude (rounding up for negatives), clip, segment from leading one.
    always_comb begin
        a_sum  = {1'b0, im} + {15'd0, is_neg};
        a_imag = 15'(a_sum >> 1);
        a_m    = (a_imag > 15'd4095) ? 12'd4095 : a_imag[11:0];
        a_seg  = '0;
        a_q    = 4'(a_m >> 1);
        if (a_m >= 12'd32) begin
            for (int unsigned i = 1; i < 8; i++) begin
                if (a_m[i + 4]) begin
                    a_seg = 3'(i);
                end
            end
            a_q = 4'(a_m >> a_seg);
        end
        a_code = {~is_neg, a_seg, a_q} ^ 8'h55;
    end

    // Output register: valid tracks in_valid, code held across invalid cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sp <= law ? a_code : mu_code;
            end
        end
    end

    assign scan_out0   = 1'b0;
    assign unused_scan = scan_en ^ scan_in0;

endmodule

// File: tb/tb_out_pcm_encoder.sv
// Scoreboard bench for out_pcm_encoder: a driver pushes expected codes,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_out_pcm_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] sr;
    logic        law;
    logic        in_valid;
    logic [7:0]  sp;
    logic        out_valid;
    logic        scan_en;
    logic        scan_in0;
    logic        scan_out0;

    typedef struct {
        logic [7:0] sp;
        logic       sweep;
        logic       neg;
        logic       mu;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_n = 0;

    logic       in_rst_q = 1'b1;
    logic       vld_q    = 1'b0;
    logic [7:0] held     = 8'h00;
    logic [7:0] prev_pos = 8'h00;
    logic [7:0] prev_neg = 8'h00;
    logic       have_pos = 1'b0;
    logic       have_neg = 1'b0;
    logic       seen[256];

    localparam int SEG_END [8] = '{63, 127, 255, 511, 1023, 2047, 4095, 8191};

    out_pcm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .sr        (sr),
        .law       (law),
        .in_valid  (in_valid),
        .sp        (sp),
        .out_valid (out_valid),
        .scan_en   (scan_en),
        .scan_in0  (scan_in0),
        .scan_out0 (scan_out0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Table-driven G.711 mu-law reference on the 14-bit magnitude scale.
    function automatic logic [7:0] mulaw_ref(input int s);
        int         mag;
        int         seg;
        logic [7:0] mask;
        if (s < 0) begin
            mag  = -s;
            mask = 8'h7F;
        end else begin
            mag  = s;
            mask = 8'hFF;
        end
        if (mag > 8158) mag = 8158;
        mag = mag + 33;
        seg = 7;
        for (int i = 7; i >= 0; i--) begin
            if (mag <= SEG_END[i]) seg = i;
        end
        return 8'((seg << 4) | ((mag >> (seg + 1)) & 15)) ^ mask;
    endfunction

    task automatic drive(input logic rst_n, input logic v, input logic l,
                         input logic [15:0] s, input logic [7:0] e, input logic sw);
        exp_t ent;
        @(posedge clk);
        #1;
        reset    = rst_n;
        in_valid = v;
        law      = l;
        sr       = s;
        scan_in0 = 1'($urandom_range(0, 1));
        if (rst_n && v) begin
            ent.sp    = e;
            ent.sweep = sw;
            ent.neg   = s[15];
            ent.mu    = !l;
            ent.idx   = vec_n;
            sb.push_back(ent);
        end
        vec_n++;
    endtask

    // Reference timing: what the registered outputs should reflect after each edge.
    always @(posedge clk) begin
        in_rst_q <= !reset;
        vld_q    <= reset && in_valid;
    end

    // Monitor: compare presented outputs against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        chk("scan_out0", 32'(scan_out0), 32'd0);
        if (in_rst_q) begin
            chk("reset_sp", 32'(sp), 32'h00);
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            held = 8'h00;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(vld_q));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got output %0h, expected none", sp);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("sp_vec%0d", e.idx), 32'(sp), 32'(e.sp));
                    held = e.sp;
                    if (e.mu && sp == e.sp) seen[e.sp] = 1'b1;
                    if (e.sweep) begin
                        if (e.neg) begin
                            if (have_neg) chk("mono_neg", 32'(sp >= prev_neg), 32'd1);
                            prev_neg = sp;
                            have_neg = 1'b1;
                        end else begin
                            if (have_pos) chk("mono_pos", 32'(sp <= prev_pos), 32'd1);
                            prev_pos = sp;
                            have_pos = 1'b1;
                        end
                    end
                end
            end else begin
                chk("hold_sp", 32'(sp), 32'(held));
            end
        end
    end

    initial begin
        int n_seen;
        foreach (seen[i]) seen[i] = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b1;
        law      = 1'b0;
        sr       = 16'h1234;
        scan_en  = 1'b0;
        scan_in0 = 1'b0;

        // reset held low with valid input
        repeat (3) drive(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);

        // mu-law directed codes
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h7E, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h7FFF, 8'h80, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h8000, 8'h7F, 1'b0);

        // A-law directed codes
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 8'hD5, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'd100,  8'hCC, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'h7FFF, 8'hAA, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h55, 1'b0);

        // law alternating every cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b1, 1'b1, 1'b0, 16'h0000, 8'hFF, 1'b0);
            else            drive(1'b1, 1'b1, 1'b1, 16'h0000, 8'hD5, 1'b0);
        end

        // valid gaps: sp must hold while inputs change underneath
        drive(1'b1, 1'b1, 1'b0, 16'd100,  8'hDF, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 16'h7FFF, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'd100,  8'hCC, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

        // mid-run reset, then idle: sp stays cleared
        drive(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);

        // mu-law sweep across the full 14-bit range
        for (int s = -8192; s <= 8191; s++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(s), mulaw_ref(s), 1'b1);
        end

        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        n_seen = 0;
        foreach (seen[i]) if (seen[i]) n_seen++;
        chk("mulaw_code_coverage", 32'(n_seen), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
